// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - five-button synchronizer, debouncer, press detector and one-hot selector
//
// Purpose: each raw push-button passes through a 2-flop synchronizer and an
// independent counter-based debouncer. A debounced rising edge produces a
// one-cycle press pulse. The highest-priority press (u > d > l > r > c) is
// latched as a one-hot selection code for the LED pattern stage.
//
// Ports:
//   sys_clk    - system clock, all logic on rising edge
//   sys_rst_n  - asynchronous active-low reset
//   btnc/u/d/l/r - raw bouncing button levels, 1 = pressed
//   btn_level  - debounced levels      {u, d, l, r, c}
//   btn_press  - one-cycle press pulse {u, d, l, r, c}
//   btn_sel    - latched one-hot code  {u, d, l, r, c}
//   sel_valid  - set once any press has been accepted since reset
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       btnc,
    input  logic       btnu,
    input  logic       btnd,
    input  logic       btnl,
    input  logic       btnr,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [4:0] btn_sel,
    output logic       sel_valid
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       w_raw;
    logic [4:0]       r_sync1;
    logic [4:0]       r_sync2;
    logic [CNT_W-1:0] r_cnt [5];
    logic [CNT_W-1:0] w_cnt_next [5];
    logic [4:0]       r_level;
    logic [4:0]       w_level_next;
    logic [4:0]       r_press;
    logic [4:0]       w_press_next;
    logic [4:0]       r_sel;
    logic [4:0]       w_sel_onehot;
    logic             r_valid;

    assign w_raw = {btnu, btnd, btnl, btnr, btnc};

    // Per-button debounce: any cycle where the synchronized input agrees with
    // the stable level restarts the count, so a bounce never accumulates.
    always_comb begin
        w_level_next = r_level;
        for (int i = 0; i < 5; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_level[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_level_next[i] = r_sync2[i];
                    w_cnt_next[i]   = '0;
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Registered alongside the level so the pulse coincides with the rise.
    assign w_press_next = w_level_next & ~r_level;

    // Priority encode the current press pulses, u highest, c lowest.
    always_comb begin
        w_sel_onehot = 5'b00000;
        if (r_press[4])      w_sel_onehot = 5'b10000;
        else if (r_press[3]) w_sel_onehot = 5'b01000;
        else if (r_press[2]) w_sel_onehot = 5'b00100;
        else if (r_press[1]) w_sel_onehot = 5'b00010;
        else if (r_press[0]) w_sel_onehot = 5'b00001;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '0;
            r_press <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            r_level <= w_level_next;
            r_press <= w_press_next;
            if (r_press != 5'b00000) begin
                r_sel   <= w_sel_onehot;
                r_valid <= 1'b1;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_press = r_press;
    assign btn_sel   = r_sel;
    assign sel_valid = r_valid;

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - directed self-checking bench for btn_debounce
module tb_btn_debounce;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       btnc, btnu, btnd, btnl, btnr;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [4:0] btn_sel;
    logic       sel_valid;

    int checks;
    int errors;

    btn_debounce #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .btnc     (btnc),
        .btnu     (btnu),
        .btnd     (btnd),
        .btnl     (btnl),
        .btnr     (btnr),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_sel  (btn_sel),
        .sel_valid(sel_valid)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".level"}, btn_level, 5'b00000);
        chk({tag, ".press"}, btn_press, 5'b00000);
        chk({tag, ".sel"},   btn_sel,   5'b00000);
        chk({tag, ".valid"}, {4'b0, sel_valid}, 5'b00000);
    endtask

    // Mid-cycle async reset with immediate check; released just after an
    // edge, which becomes edge 0 of the next test.
    task automatic do_reset(input string tag);
        step(1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero(tag);
        step(3);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        sys_rst_n = 1'b0;
        {btnc, btnu, btnd, btnl, btnr} = 5'b00000;
        #1;
        chk_all_zero("por");
        step(2);
        sys_rst_n = 1'b1;

        // btnu steady from edge 0: level/press at edge 6, sel/valid at edge 7
        step(1);
        btnu = 1'b1;
        step(5);
        chk("u.e5.level", btn_level, 5'b00000);
        chk("u.e5.press", btn_press, 5'b00000);
        step(1);
        chk("u.e6.level", btn_level, 5'b10000);
        chk("u.e6.press", btn_press, 5'b10000);
        chk("u.e6.sel",   btn_sel,   5'b00000);
        chk("u.e6.valid", {4'b0, sel_valid}, 5'b00000);
        step(1);
        chk("u.e7.press", btn_press, 5'b00000);
        chk("u.e7.sel",   btn_sel,   5'b10000);
        chk("u.e7.valid", {4'b0, sel_valid}, 5'b00001);
        btnu = 1'b0;
        step(8);
        chk("u.release.level", btn_level, 5'b00000);
        chk("u.release.sel",   btn_sel,   5'b10000);
        do_reset("rst1");

        // btnc bounce 1,0,1,0 every 2 cycles, then steady 1 from edge 8
        step(1);
        btnc = 1'b1;
        step(2); btnc = 1'b0;
        step(2); btnc = 1'b1;
        step(2); btnc = 1'b0;
        step(2); btnc = 1'b1;
        for (int e = 9; e <= 13; e++) begin
            step(1);
            chk($sformatf("c.e%0d.press", e), btn_press, 5'b00000);
        end
        chk("c.e13.level", btn_level, 5'b00000);
        step(1);
        chk("c.e14.press", btn_press, 5'b00001);
        chk("c.e14.level", btn_level, 5'b00001);
        step(1);
        chk("c.e15.press", btn_press, 5'b00000);
        chk("c.e15.sel",   btn_sel,   5'b00001);
        btnc = 1'b0;
        do_reset("rst2");

        // btnd and btnr together: both pulse, d wins priority
        step(1);
        btnd = 1'b1;
        btnr = 1'b1;
        step(6);
        chk("dr.e6.press", btn_press, 5'b01010);
        chk("dr.e6.level", btn_level, 5'b01010);
        step(1);
        chk("dr.e7.press", btn_press, 5'b00000);
        chk("dr.e7.sel",   btn_sel,   5'b01000);
        chk("dr.e7.valid", {4'b0, sel_valid}, 5'b00001);
        btnd = 1'b0;
        btnr = 1'b0;
        do_reset("rst3");

        // btnl press, release at edge 20, level falls at edge 26
        step(1);
        btnl = 1'b1;
        step(6);
        chk("l.e6.press", btn_press, 5'b00100);
        step(1);
        chk("l.e7.sel", btn_sel, 5'b00100);
        step(13);
        btnl = 1'b0;
        for (int e = 21; e <= 25; e++) begin
            step(1);
            chk($sformatf("l.e%0d.level", e), btn_level, 5'b00100);
        end
        step(1);
        chk("l.e26.level", btn_level, 5'b00000);
        chk("l.e26.press", btn_press, 5'b00000);
        step(1);
        chk("l.e27.press", btn_press, 5'b00000);
        chk("l.e27.sel",   btn_sel,   5'b00100);
        chk("l.e27.valid", {4'b0, sel_valid}, 5'b00001);

        // btnu press, reset 3 cycles in while held, re-accepted after release
        step(1);
        btnu = 1'b1;
        step(3);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("u_rst.mid");
        step(3);
        chk_all_zero("u_rst.held");
        sys_rst_n = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1);
            chk($sformatf("u_rst.e%0d.press", e), btn_press, 5'b00000);
        end
        step(1);
        chk("u_rst.e6.press", btn_press, 5'b10000);
        chk("u_rst.e6.level", btn_level, 5'b10000);
        step(1);
        chk("u_rst.e7.sel",   btn_sel,   5'b10000);
        chk("u_rst.e7.valid", {4'b0, sel_valid}, 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
